bus_unit_8b: RTL
================

BUS_UNIT_8B -- requirements
Module: bus_unit_8b

Interface
REQ-001 SHALL have parameter WAIT_LIMIT, default 15, max consecutive bus_rdy-low cycles tolerated per byte cycle.
REQ-002 SHALL have ports, in order:
- clk  in  1  sole clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- req  in  1  core access request; sampled only in IDLE
- we  in  1  1 = write, 0 = read; latched with req
- wide  in  1  1 = 16-bit access (two byte cycles), 0 = byte; latched with req
- addr  in  16  access address from the datapath effective-address output
- wdata  in  16  store data from the datapath register-bank output
- rdata  out  16  read result, feeds the datapath t16 input
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle timeout pulse, coincident with done
- busy  out  1  high whenever state is not IDLE
- bus_addr  out  16  external byte address
- bus_dout  out  8  external write data
- bus_din  in  8  external read data
- bus_rd  out  1  external read strobe
- bus_wr  out  1  external write strobe
- bus_rdy  in  1  external ready; low inserts wait states

Function
REQ-003 SHALL implement states IDLE, LO, HI, FIN.
REQ-004 In IDLE with req=1, SHALL latch addr, wdata, we and wide and move to LO next cycle; req in any other state SHALL be ignored.
REQ-005 LO SHALL drive bus_addr = latched addr, bus_rd = ~we, bus_wr = we, bus_dout = wdata[7:0].
REQ-006 HI SHALL drive bus_addr = latched addr + 1, modulo 2^16 (0xFFFF wraps to 0x0000), bus_dout = wdata[15:8], with strobes as in LO.
REQ-007 In IDLE and FIN, bus_rd, bus_wr, bus_addr and bus_dout SHALL be 0.
REQ-008 A byte cycle SHALL complete in the cycle bus_rdy=1 while in LO or HI; on a read, bus_din SHALL be captured on that edge.
REQ-009 On LO completion: wide=1 -> HI, wide=0 -> FIN; on HI completion -> FIN.
REQ-010 Byte order is little-endian: LO byte goes to rdata[7:0], HI byte to rdata[15:8].
REQ-011 A byte read SHALL return rdata = {8'h00, byte}; zero-extension only, sign extension is the datapath's job.
REQ-012 rdata SHALL update only in FIN of a successful read, and otherwise hold; writes and timeouts SHALL leave it unchanged.
REQ-013 FIN SHALL assert done=1 for exactly one cycle, then return to IDLE; busy=1 in LO, HI and FIN.
REQ-014 A wait counter SHALL clear on entry to LO and to HI, and increment each cycle bus_rdy=0 in LO/HI.
REQ-015 When the counter reaches WAIT_LIMIT with bus_rdy still 0, SHALL go directly to FIN with err=1 alongside done, skipping any remaining HI cycle.
REQ-016 If bus_rdy=1 in the same cycle the limit is reached, completion SHALL take priority and no error is raised.
REQ-017 Latency with zero waits: byte access = req at cycle N, done at N+2; word access = done at N+3; each wait cycle adds 1.
REQ-018 Back-to-back throughput: the next req SHALL be accepted no earlier than the cycle after done.

Reset
REQ-019 rst=1 SHALL force IDLE at the next edge from any state, including mid-LO/HI with strobes active.
REQ-020 Reset values SHALL be: rdata=0, done=0, err=0, busy=0, bus_rd=0, bus_wr=0, bus_addr=0, bus_dout=0; wait counter and latches cleared.
REQ-021 The aborted access SHALL produce no done or err pulse.

Structure
REQ-022 State encoding constants and the default WAIT_LIMIT SHALL live in a shared core package.
REQ-023 The wait counter and limit compare SHALL be one sub-module, bus_wait_timer (clear, count-enable, expired output).
REQ-024 Latency above the bus is not assumed; no FIFO or multi-outstanding support.

Verification
REQ-025 Byte read, addr=0x1234, bus_din=0xA5, rdy=1 -> bus_addr 0x1234 for one cycle; done at N+2; rdata=0x00A5.
REQ-026 Word write, addr=0x2000, wdata=0xBEEF -> bus_wr with 0x2000/0xEF, then 0x2001/0xBE; done at N+3; rdata unchanged.
REQ-027 Word read, addr=0xFFFF, din 0x34 then 0x12 -> second bus_addr=0x0000; rdata=0x1234.
REQ-028 Byte read with bus_rdy low 3 cycles -> done at N+5, no err; bus_rdy never high, WAIT_LIMIT=15 -> err and done after 15 wait cycles, rdata unchanged.
REQ-029 Word read, rst asserted in HI -> strobes 0 and busy 0 next cycle; no done; new req accepted immediately after.

Source files
------------

// File: rtl/bus_unit_8b_pkg.sv
// Shared definitions for the 8-bit external bus unit: state encoding and default timeout.
package bus_unit_8b_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2,
        ST_FIN  = 2'd3
    } bus_state_t;

    localparam int unsigned WAIT_LIMIT_DEFAULT = 15;

endpackage

// File: rtl/bus_unit_8b_bus_wait_timer.sv
// Per-byte-cycle wait-state counter; expired is high once WAIT_LIMIT low-ready cycles have been counted.
module bus_wait_timer #(
    parameter int unsigned WAIT_LIMIT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    localparam int unsigned CW = $clog2(WAIT_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(WAIT_LIMIT);

    logic [CW-1:0] count;

    assign expired = (count == LIMIT);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (count_en && !expired) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/bus_unit_8b.sv
// Bridges 8/16-bit core accesses onto an 8-bit external bus, little-endian, with wait-state timeout.
module bus_unit_8b
    import bus_unit_8b_pkg::*;
#(
    parameter int unsigned WAIT_LIMIT = WAIT_LIMIT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic        wide,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    output logic [15:0] rdata,
    output logic        done,
    output logic        err,
    output logic        busy,
    output logic [15:0] bus_addr,
    output logic [7:0]  bus_dout,
    input  logic [7:0]  bus_din,
    output logic        bus_rd,
    output logic        bus_wr,
    input  logic        bus_rdy
);

    bus_state_t  state, state_next;
    logic [15:0] addr_q;
    logic [15:0] wdata_q;
    logic        we_q;
    logic        wide_q;
    logic [7:0]  lo_q;
    logic [15:0] rdata_q;
    logic        to_q;
    logic        byte_done;
    logic        timeout;
    logic        in_cycle;
    logic        expired;

    assign in_cycle = (state == ST_LO) || (state == ST_HI);
    assign rdata    = rdata_q;

    // Counter restarts every time a byte cycle is not in progress or just completed,
    // which covers entry to both LO and HI.
    bus_wait_timer #(
        .WAIT_LIMIT(WAIT_LIMIT)
    ) u_wait (
        .clk      (clk),
        .rst      (rst),
        .clear    (!in_cycle || byte_done),
        .count_en (in_cycle && !bus_rdy),
        .expired  (expired)
    );

    always_comb begin
        state_next = state;
        busy       = (state != ST_IDLE);
        done       = (state == ST_FIN);
        err        = (state == ST_FIN) && to_q;
        bus_addr   = '0;
        bus_dout   = '0;
        bus_rd     = 1'b0;
        bus_wr     = 1'b0;
        byte_done  = 1'b0;
        timeout    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req) state_next = ST_LO;
            end
            ST_LO: begin
                bus_addr = addr_q;
                bus_dout = wdata_q[7:0];
                bus_rd   = !we_q;
                bus_wr   = we_q;
                if (bus_rdy) begin
                    byte_done  = 1'b1;
                    state_next = wide_q ? ST_HI : ST_FIN;
                end else if (expired) begin
                    timeout    = 1'b1;
                    state_next = ST_FIN;
                end
            end
            ST_HI: begin
                bus_addr = addr_q + 16'd1;
                bus_dout = wdata_q[15:8];
                bus_rd   = !we_q;
                bus_wr   = we_q;
                if (bus_rdy) begin
                    byte_done  = 1'b1;
                    state_next = ST_FIN;
                end else if (expired) begin
                    timeout    = 1'b1;
                    state_next = ST_FIN;
                end
            end
            ST_FIN: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            wide_q  <= 1'b0;
            lo_q    <= '0;
            rdata_q <= '0;
            to_q    <= 1'b0;
        end else begin
            state <= state_next;
            to_q  <= timeout;
            if (state == ST_IDLE && req) begin
                addr_q  <= addr;
                wdata_q <= wdata;
                we_q    <= we;
                wide_q  <= wide;
            end
            // rdata is written only by the final byte of a read, so it is valid alongside done.
            if (byte_done && !we_q) begin
                if (state == ST_LO && wide_q) begin
                    lo_q <= bus_din;
                end else if (state == ST_LO) begin
                    rdata_q <= {8'h00, bus_din};
                end else begin
                    rdata_q <= {bus_din, lo_q};
                end
            end
        end
    end

endmodule
